// File: rtl/ltc2666x2_scheduler.sv
// Command-word scheduler for two LTC2666 DACs sharing one SPI driver: builds the
// next 24-bit word per chip after each consume, issuing span-all first and then round-robin channel refreshes.
module ltc2666x2_scheduler #(
  parameter int unsigned N_B       = 24,
  parameter logic [2:0]  SPAN_INIT = 3'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           spi_ready,
  input  logic           spi_state,
  input  logic [255:0]   codes_in,
  input  logic [15:0]    en_mask,
  input  logic           span_req,
  input  logic [2:0]     span_sel,
  output logic [N_B-1:0] data_out0,
  output logic [N_B-1:0] data_out1,
  output logic           span_busy,
  output logic           sweep_done
);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;
  typedef logic [N_B-1:0] word_t;
  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } pick_t;

  localparam logic [3:0] CMD_WRITE = 4'h3;
  localparam logic [3:0] CMD_SPAN  = 4'hE;
  localparam word_t      WORD_NOP  = 24'hF00000;

  function automatic word_t span_word(input logic [2:0] span);
    return {CMD_SPAN, 4'h0, 13'd0, span};
  endfunction

  // First enabled channel at or after start, searching cyclically over 0..7.
  function automatic pick_t find_next(input logic [7:0] en, input logic [2:0] start);
    pick_t      p;
    logic [2:0] cand;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      cand = start + 3'(i);
      if (en[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  state_e     state_q     [2];
  state_e     state_d     [2];
  logic [1:0] span_pend_q, span_pend_d;
  logic [2:0] span_code_q [2];
  logic [2:0] span_code_d [2];
  logic [2:0] ptr_q       [2];
  logic [2:0] ptr_d       [2];
  word_t      word_q      [2];
  word_t      word_d      [2];
  logic       has_prev_q, has_prev_d;
  logic       sweep_done_q, sweep_done_d;
  logic       span_busy_q, span_busy_d;

  logic [1:0]  consume;
  logic [1:0]  is_span;
  pick_t       pick      [2];
  logic [15:0] pick_code [2];
  logic [2:0]  prev_idx1;

  assign consume      = {spi_ready & spi_state, spi_ready & ~spi_state};
  assign is_span[0]   = (word_q[0][N_B-1 -: 4] == CMD_SPAN);
  assign is_span[1]   = (word_q[1][N_B-1 -: 4] == CMD_SPAN);
  assign pick[0]      = find_next(en_mask[7:0],  ptr_q[0]);
  assign pick[1]      = find_next(en_mask[15:8], ptr_q[1]);
  assign pick_code[0] = codes_in[{1'b0, pick[0].idx, 4'b0000} +: 16];
  assign pick_code[1] = codes_in[{1'b1, pick[1].idx, 4'b0000} +: 16];
  // ptr always sits one past the last channel chip1 wrote.
  assign prev_idx1    = ptr_q[1] - 3'd1;

  // NOTE: every next-state signal is given its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    has_prev_d   = has_prev_q;
    sweep_done_d = 1'b0;
    span_pend_d  = span_pend_q;
    for (int c = 0; c < 2; c++) begin
      state_d[c]     = state_q[c];
      span_code_d[c] = span_code_q[c];
      ptr_d[c]       = ptr_q[c];
      word_d[c]      = word_q[c];
      if (consume[c]) begin
        if (state_q[c] == ST_INIT && is_span[c]) state_d[c] = ST_RUN;
        span_pend_d[c] = 1'b0;
        if (span_pend_q[c] && !is_span[c]) begin
          word_d[c] = span_word(span_code_q[c]);
        end else if (pick[c].found) begin
          word_d[c] = {CMD_WRITE, 1'b0, pick[c].idx, pick_code[c]};
          ptr_d[c]  = pick[c].idx + 3'd1;
          if (c == 1) begin
            sweep_done_d = has_prev_q && (pick[c].idx <= prev_idx1);
            has_prev_d   = 1'b1;
          end
        end else begin
          word_d[c] = WORD_NOP;
        end
      end
      // A request landing with a consume still lets that consume use the old state.
      if (span_req) begin
        span_pend_d[c] = 1'b1;
        span_code_d[c] = span_sel;
      end
    end
    span_busy_d = (|span_pend_d) || (state_d[0] == ST_INIT) || (state_d[1] == ST_INIT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]     <= ST_INIT;
        span_code_q[c] <= SPAN_INIT;
        ptr_q[c]       <= 3'd0;
        word_q[c]      <= span_word(SPAN_INIT);
      end
      span_pend_q  <= 2'b00;
      has_prev_q   <= 1'b0;
      sweep_done_q <= 1'b0;
      span_busy_q  <= 1'b1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        state_q[c]     <= state_d[c];
        span_code_q[c] <= span_code_d[c];
        ptr_q[c]       <= ptr_d[c];
        word_q[c]      <= word_d[c];
      end
      span_pend_q  <= span_pend_d;
      has_prev_q   <= has_prev_d;
      sweep_done_q <= sweep_done_d;
      span_busy_q  <= span_busy_d;
    end
  end

  assign data_out0  = word_q[0];
  assign data_out1  = word_q[1];
  assign span_busy  = span_busy_q;
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_ltc2666x2_scheduler.sv
// Self-checking bench for ltc2666x2_scheduler: a per-cycle reference model plus
// directed consume sequences with hand-computed command words.
module tb_ltc2666x2_scheduler;

  localparam logic [2:0] SPAN_INIT = 3'd2;

  logic         clk = 1'b0;
  logic         rst;
  logic         spi_ready;
  logic         spi_state;
  logic [255:0] codes_in;
  logic [15:0]  en_mask;
  logic         span_req;
  logic [2:0]   span_sel;
  logic [23:0]  data_out0;
  logic [23:0]  data_out1;
  logic         span_busy;
  logic         sweep_done;

  int n_checks = 0;
  int n_fail   = 0;
  int sweep_cnt = 0;

  ltc2666x2_scheduler #(.N_B(24), .SPAN_INIT(SPAN_INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .spi_ready  (spi_ready),
    .spi_state  (spi_state),
    .codes_in   (codes_in),
    .en_mask    (en_mask),
    .span_req   (span_req),
    .span_sel   (span_sel),
    .data_out0  (data_out0),
    .data_out1  (data_out1),
    .span_busy  (span_busy),
    .sweep_done (sweep_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] code_of(input int k);
    return 16'(k * 32'h1001);
  endfunction

  // Reference model: what each chip must hold after every clock edge.
  logic [23:0] m_word [2];
  logic [2:0]  m_code [2];
  bit          m_pend [2];
  bit          m_init [2];
  int          m_ptr  [2];
  int          m_prev [2];
  bit          m_sweep;
  bit          m_busy;

  task automatic model_step();
    int n;
    int ch;
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        m_word[c] = {4'hE, 4'h0, 13'd0, SPAN_INIT};
        m_code[c] = SPAN_INIT;
        m_pend[c] = 0;
        m_init[c] = 1;
        m_ptr[c]  = 0;
        m_prev[c] = -1;
      end
      m_sweep = 0;
      m_busy  = 1;
    end else begin
      m_sweep = 0;
      for (int c = 0; c < 2; c++) begin
        if (spi_ready && (int'(spi_state) == c)) begin
          m_init[c] = 0;
          if (m_pend[c] && m_word[c][23:20] != 4'hE) begin
            m_word[c] = {4'hE, 4'h0, 13'd0, m_code[c]};
            m_pend[c] = 0;
          end else begin
            m_pend[c] = 0;
            n = -1;
            for (int k = 0; k < 8; k++)
              if (n < 0 && en_mask[8*c + (m_ptr[c] + k) % 8]) n = (m_ptr[c] + k) % 8;
            if (n >= 0) begin
              ch = 8*c + n;
              m_word[c] = {4'h3, 1'b0, 3'(n), codes_in[16*ch +: 16]};
              if (c == 1 && m_prev[1] >= 0 && n <= m_prev[1]) m_sweep = 1;
              m_prev[c] = n;
              m_ptr[c]  = (n + 1) % 8;
            end else begin
              m_word[c] = 24'hF00000;
            end
          end
        end
        if (span_req) begin
          m_pend[c] = 1;
          m_code[c] = span_sel;
        end
      end
      m_busy = m_pend[0] || m_pend[1] || m_init[0] || m_init[1];
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #2;
    check("model data_out0",  {8'h0, data_out0}, {8'h0, m_word[0]});
    check("model data_out1",  {8'h0, data_out1}, {8'h0, m_word[1]});
    check("model span_busy",  {31'h0, span_busy},  {31'h0, m_busy});
    check("model sweep_done", {31'h0, sweep_done}, {31'h0, m_sweep});
  end

  always @(negedge clk) if (sweep_done === 1'b1) sweep_cnt++;

  // Called at a negedge: returns the word the driver latches, pulses ready, idles one cycle.
  task automatic send(input int c, output logic [23:0] w);
    w = (c == 1) ? data_out1 : data_out0;
    spi_ready = 1'b1;
    spi_state = (c == 1);
    @(negedge clk);
    spi_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_chk(input int c, input logic [23:0] exp, input string name);
    logic [23:0] w;
    send(c, w);
    check(name, {8'h0, w}, {8'h0, exp});
  endtask

  initial begin
    logic [23:0] w;
    int cnt0;
    rst = 1'b1; spi_ready = 1'b0; spi_state = 1'b0;
    span_req = 1'b0; span_sel = 3'd0; en_mask = 16'hFFFF;
    for (int k = 0; k < 16; k++) codes_in[16*k +: 16] = code_of(k);
    repeat (2) @(negedge clk);

    // T1: reset state and first words
    check("reset data_out0", {8'h0, data_out0}, 32'hE00002);
    check("reset data_out1", {8'h0, data_out1}, 32'hE00002);
    check("reset span_busy", {31'h0, span_busy}, 32'd1);
    check("reset sweep_done", {31'h0, sweep_done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    send_chk(0, 24'hE00002, "t1 chip0 span");
    check("t1 busy after chip0 span", {31'h0, span_busy}, 32'd1);
    send_chk(1, 24'hE00002, "t1 chip1 span");
    check("t1 busy after both spans", {31'h0, span_busy}, 32'd0);

    // T2: two full sweeps in address order
    cnt0 = sweep_cnt;
    for (int i = 0; i < 17; i++) begin
      send(0, w);
      check("t2 chip0 word", {8'h0, w}, {8'h0, 4'h3, 1'b0, 3'(i % 8), code_of(i % 8)});
      send(1, w);
      check("t2 chip1 word", {8'h0, w}, {8'h0, 4'h3, 1'b0, 3'(i % 8), code_of(8 + i % 8)});
    end
    check("t2 sweep pulses", 32'(sweep_cnt - cnt0), 32'd2);

    // T3: chip0 ch0+ch7 only, chip1 fully masked
    rst = 1'b1;
    en_mask = 16'h0081;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    cnt0 = sweep_cnt;
    send_chk(0, 24'hE00002, "t3 chip0 span");
    send_chk(1, 24'hE00002, "t3 chip1 span");
    for (int j = 0; j < 4; j++) begin
      send_chk(0, (j % 2 == 0) ? 24'h300000 : 24'h377007, "t3 chip0 alt");
      send_chk(1, 24'hF00000, "t3 chip1 nop");
    end
    check("t3 no sweep pulse", 32'(sweep_cnt - cnt0), 32'd0);

    // T4: span request mid-sweep, sweep resumes at saved pointer
    en_mask = 16'hFFFF;
    span_req = 1'b1; span_sel = 3'd4;
    @(negedge clk);
    span_req = 1'b0;
    check("t4 busy after req", {31'h0, span_busy}, 32'd1);
    send_chk(0, 24'h300000, "t4 chip0 prebuilt");
    send_chk(1, 24'hF00000, "t4 chip1 prebuilt");
    send_chk(0, 24'hE00004, "t4 chip0 span4");
    send_chk(1, 24'hE00004, "t4 chip1 span4");
    check("t4 busy cleared", {31'h0, span_busy}, 32'd0);
    send_chk(0, 24'h311001, "t4 chip0 resume");
    send_chk(1, 24'h308008, "t4 chip1 resume");

    // Back-to-back requests, newest code wins; ch3 code set up for T5
    codes_in[16*3 +: 16] = 16'h1234;
    span_req = 1'b1; span_sel = 3'd3;
    @(negedge clk);
    span_sel = 3'd5;
    @(negedge clk);
    span_req = 1'b0;
    send_chk(0, 24'h322002, "t4b chip0 prebuilt");
    send_chk(1, 24'h319009, "t4b chip1 prebuilt");

    // T5: code change one cycle before the consume that builds ch3
    codes_in[16*3 +: 16] = 16'hBEEF;
    @(negedge clk);
    send_chk(0, 24'hE00005, "t4b chip0 span5");
    send_chk(1, 24'hE00005, "t4b chip1 span5");
    send_chk(0, 24'h33BEEF, "t5 chip0 new code");
    send_chk(1, 24'h32A00A, "t4b chip1 single span");

    // T6: reset during a chip1 frame, ready in the reset cycle ignored
    spi_ready = 1'b1; spi_state = 1'b1; rst = 1'b1;
    @(negedge clk);
    spi_ready = 1'b0;
    @(negedge clk);
    check("t6 data_out0", {8'h0, data_out0}, 32'hE00002);
    check("t6 data_out1", {8'h0, data_out1}, 32'hE00002);
    check("t6 span_busy", {31'h0, span_busy}, 32'd1);
    check("t6 sweep_done", {31'h0, sweep_done}, 32'd0);
    rst = 1'b0;
    en_mask = 16'h0400;
    @(negedge clk);
    send_chk(0, 24'hE00002, "t6 chip0 span");
    send_chk(1, 24'hE00002, "t6 chip1 span");
    cnt0 = sweep_cnt;
    send_chk(1, 24'h32A00A, "t6 single ch a");
    send_chk(1, 24'h32A00A, "t6 single ch b");
    check("t6 single-channel pulses", 32'(sweep_cnt - cnt0), 32'd2);
    send_chk(0, 24'hF00000, "t6 chip0 nop");

    // Request coinciding with a chip1 consume: that consume uses the old state
    span_req = 1'b1; span_sel = 3'd6; spi_ready = 1'b1; spi_state = 1'b1;
    @(negedge clk);
    span_req = 1'b0; spi_ready = 1'b0;
    @(negedge clk);
    send_chk(1, 24'h32A00A, "coincident chip1 write");
    send_chk(1, 24'hE00006, "coincident chip1 span6");
    send_chk(1, 24'h32A00A, "coincident chip1 resume");
    send_chk(0, 24'hF00000, "coincident chip0 nop");
    send_chk(0, 24'hE00006, "coincident chip0 span6");
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
